// File: rtl/fifo36_to_ll8_pkg.sv
// fifo36_to_ll8_pkg: f36 word field positions and byte-count helper shared by packers and unpackers.
package fifo36_to_ll8_pkg;
   localparam int F36_OCC_HI = 35;
   localparam int F36_OCC_LO = 34;
   localparam int F36_EOF    = 33;
   localparam int F36_SOF    = 32;
   localparam int F36_B0_LO  = 24;
   localparam int F36_B1_LO  = 16;
   localparam int F36_B2_LO  = 8;
   localparam int F36_B3_LO  = 0;
   localparam int BYTE_W     = 8;
   // occ only trims the word on eof; occ=0 always means a full word
   function automatic logic [1:0] last_byte_idx(input logic [1:0] occ, input logic eof);
      return (eof && occ != 2'd0) ? occ - 2'd1 : 2'd3;
   endfunction
endpackage

// File: rtl/fifo36_to_ll8.sv
// fifo36_to_ll8: serialises 36-bit FIFO words into an active-low 8-bit LocalLink byte stream.
module fifo36_to_ll8
   import fifo36_to_ll8_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic [35:0] f36_data,
   input  logic        f36_src_rdy_i,
   output logic        f36_dst_rdy_o,
   output logic [7:0]  ll_data,
   output logic        ll_sof_n,
   output logic        ll_eof_n,
   output logic        ll_src_rdy_n,
   input  logic        ll_dst_rdy_n
);
   logic [35:0] r_wd;
   logic        r_valid;
   logic [1:0]  r_ptr;
   logic [1:0]  w_last;
   logic        w_at_last;
   logic        w_xfer;
   logic        w_load;
   assign w_last    = last_byte_idx(r_wd[F36_OCC_HI:F36_OCC_LO], r_wd[F36_EOF]);
   assign w_at_last = r_ptr == w_last;
   assign w_xfer    = r_valid & ~ll_dst_rdy_n;
   // next word loads on the same edge the last byte leaves, so frames stream without bubbles
   assign f36_dst_rdy_o = ~reset & ~clear & (~r_valid | (w_xfer & w_at_last));
   assign w_load        = f36_src_rdy_i & f36_dst_rdy_o;
   assign ll_data = (r_ptr == 2'd0) ? r_wd[F36_B0_LO +: BYTE_W] :
                    (r_ptr == 2'd1) ? r_wd[F36_B1_LO +: BYTE_W] :
                    (r_ptr == 2'd2) ? r_wd[F36_B2_LO +: BYTE_W] :
                                      r_wd[F36_B3_LO +: BYTE_W];
   assign ll_src_rdy_n = ~r_valid;
   assign ll_sof_n     = ~(r_valid & r_wd[F36_SOF] & (r_ptr == 2'd0));
   assign ll_eof_n     = ~(r_valid & r_wd[F36_EOF] & w_at_last);
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_wd    <= '0;
         r_valid <= 1'b0;
         r_ptr   <= 2'd0;
      end else if (w_load) begin
         r_wd    <= f36_data;
         r_valid <= 1'b1;
         r_ptr   <= 2'd0;
      end else if (w_xfer) begin
         r_valid <= ~w_at_last;
         r_ptr   <= w_at_last ? 2'd0 : r_ptr + 2'd1;
      end
   end
endmodule

// File: tb/tb_fifo36_to_ll8.sv
// tb_fifo36_to_ll8: scoreboard bench; accepted words expand into expected bytes, a monitor checks the LocalLink side.
module tb_fifo36_to_ll8;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic [35:0] f36_data = '0;
   logic        f36_src_rdy_i = 1'b0;
   logic        f36_dst_rdy_o;
   logic [7:0]  ll_data;
   logic        ll_sof_n, ll_eof_n, ll_src_rdy_n;
   logic        ll_dst_rdy_n = 1'b0;

   typedef struct packed {
      logic [7:0] d;
      logic       s;
      logic       e;
      logic       l;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_fail = 0;
   int   sink_mode = 0;
   int   run = 0;
   int   max_run = 0;
   logic exp_rdy;

   fifo36_to_ll8 dut (
      .clk(clk), .reset(reset), .clear(clear),
      .f36_data(f36_data), .f36_src_rdy_i(f36_src_rdy_i), .f36_dst_rdy_o(f36_dst_rdy_o),
      .ll_data(ll_data), .ll_sof_n(ll_sof_n), .ll_eof_n(ll_eof_n),
      .ll_src_rdy_n(ll_src_rdy_n), .ll_dst_rdy_n(ll_dst_rdy_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a word carries 4 bytes unless eof with nonzero occ, then occ bytes.
   task automatic push_word(input logic [35:0] w);
      logic [7:0] b[4];
      int n;
      b[0] = w[31:24]; b[1] = w[23:16]; b[2] = w[15:8]; b[3] = w[7:0];
      n = (w[33] && w[35:34] != 2'd0) ? int'(w[35:34]) : 4;
      for (int i = 0; i < n; i++)
         q.push_back('{d: b[i], s: w[32] && i == 0, e: w[33] && i == n - 1, l: i == n - 1});
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      case (sink_mode)
         0: ll_dst_rdy_n = 1'b0;
         1: ll_dst_rdy_n = ($urandom_range(0, 3) == 0);
         2: ll_dst_rdy_n = ~ll_dst_rdy_n;
         default: ll_dst_rdy_n = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      if (reset) begin
         run = 0;
      end else if (clear) begin
         q.delete();
         run = 0;
         chk("clear_dst_rdy", {31'd0, f36_dst_rdy_o}, 32'd0);
      end else begin
         exp_rdy = 1'b0;
         if (!ll_src_rdy_n) begin
            run++;
            if (run > max_run) max_run = run;
            if (q.size() == 0) begin
               chk("unexpected_byte", {22'd0, ll_data, ll_sof_n, ll_eof_n}, 32'hFFFFFFFF);
            end else begin
               chk("byte", {22'd0, ll_data, ll_sof_n, ll_eof_n}, {22'd0, q[0].d, ~q[0].s, ~q[0].e});
               exp_rdy = !ll_dst_rdy_n && q[0].l;
               if (!ll_dst_rdy_n) void'(q.pop_front());
            end
         end else begin
            run = 0;
            exp_rdy = 1'b1;
         end
         chk("dst_rdy", {31'd0, f36_dst_rdy_o}, {31'd0, exp_rdy});
         if (f36_src_rdy_i && f36_dst_rdy_o) push_word(f36_data);
      end
   end

   task automatic send(input logic [35:0] w);
      f36_data = w;
      f36_src_rdy_i = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (f36_dst_rdy_o) begin
            @(posedge clk);
            #1;
            f36_src_rdy_i = 1'b0;
            return;
         end
      end
      chk("send_timeout", 32'd1, 32'd0);
      f36_src_rdy_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_src_rdy_n", {31'd0, ll_src_rdy_n}, 32'd1);
      chk("rst_sof_n", {31'd0, ll_sof_n}, 32'd1);
      chk("rst_eof_n", {31'd0, ll_eof_n}, 32'd1);
      chk("rst_data", {24'd0, ll_data}, 32'd0);
      chk("rst_dst_rdy", {31'd0, f36_dst_rdy_o}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(2);
      send({2'd0, 1'b0, 1'b1, 32'h00010203});
      send({2'd0, 1'b1, 1'b0, 32'h04050607});
      idle(6);
      send({2'd0, 1'b0, 1'b1, 32'h00010203});
      send({2'd1, 1'b1, 1'b0, 32'h04AABBCC});
      send({2'd1, 1'b1, 1'b1, 32'h5A123456});
      idle(6);
      sink_mode = 2;
      send({2'd0, 1'b0, 1'b1, 32'h00010203});
      send({2'd0, 1'b1, 1'b0, 32'h04050607});
      idle(20);
      sink_mode = 0;
      idle(4);
      max_run = 0;
      send({2'd3, 1'b1, 1'b1, 32'h11223344});
      send({2'd0, 1'b1, 1'b1, 32'h55667788});
      idle(8);
      chk("gapless_run", max_run, 32'd7);
      send({2'd0, 1'b0, 1'b1, 32'hDEADBEEF});
      @(negedge clk);
      @(negedge clk);
      sink_mode = 3;
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      sink_mode = 0;
      @(negedge clk);
      chk("post_clear_src_rdy_n", {31'd0, ll_src_rdy_n}, 32'd1);
      send({2'd0, 1'b1, 1'b1, 32'h0A0B0C0D});
      idle(6);
      sink_mode = 1;
      for (int i = 0; i < 150; i++) begin
         idle($urandom_range(0, 2));
         send({$urandom_range(0, 3) == 0 ? 4'($urandom) : {2'($urandom), 1'b0, 1'($urandom)}, 32'($urandom)});
      end
      sink_mode = 0;
      for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge clk);
      idle(2);
      chk("drain", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
